// File: rtl/rgb_pwm_pkg.sv
// Shared types and constants for the RGB PWM controller: FSM states,
// register map and CTRL bit layout.
package rgb_pwm_pkg;

    localparam int unsigned ADDR_W   = 3;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned DUTY_W   = 8;
    localparam int unsigned NUM_CHAN = 3;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_SETTLE   = 2'd1,
        ST_ON       = 2'd2,
        ST_OFF      = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_CTRL     = 3'd0;
    localparam logic [ADDR_W-1:0] ADDR_PSC_LO   = 3'd1;
    localparam logic [ADDR_W-1:0] ADDR_PSC_HI   = 3'd2;
    localparam logic [ADDR_W-1:0] ADDR_DUTY0    = 3'd3;
    localparam logic [ADDR_W-1:0] ADDR_DUTY1    = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_DUTY2    = 3'd5;
    localparam logic [ADDR_W-1:0] ADDR_ON_TIME  = 3'd6;
    localparam logic [ADDR_W-1:0] ADDR_OFF_TIME = 3'd7;

    localparam int unsigned CTRL_EN_BIT    = 0;
    localparam int unsigned CTRL_BLINK_BIT = 1;

    // CTRL register contents; en sits in bit 0
    typedef struct packed {
        logic blink_en;
        logic en;
    } ctrl_t;

endpackage

// File: rtl/rgb_pwm_chan.sv
// One PWM channel: active duty register, reloaded from its shadow on the
// load strobe, and the registered compare against the shared period counter.
module rgb_pwm_chan
    import rgb_pwm_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              run_nxt,
    input  logic [DUTY_W-1:0] duty_shadow,
    input  logic [DUTY_W-1:0] cnt_nxt,
    output logic              pwm
);

    logic [DUTY_W-1:0] duty_act;
    logic [DUTY_W-1:0] duty_nxt;

    always_comb begin
        duty_nxt = duty_act;
        if (load) begin
            duty_nxt = duty_shadow;
        end
    end

    // Compare uses next-cycle values so pwm lines up with the FSM state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_act <= '0;
            pwm      <= 1'b0;
        end else begin
            duty_act <= duty_nxt;
            pwm      <= run_nxt && (cnt_nxt < duty_nxt);
        end
    end

endmodule

// File: rtl/rgb_pwm_ctrl.sv
// RGB LED driver controller: register port, prescaled 8-bit PWM on three
// channels, bias-settle delay and on/off blink sequencing.
module rgb_pwm_ctrl
    import rgb_pwm_pkg::*;
#(
    parameter int unsigned PSC_W      = 10,
    parameter int unsigned SETTLE_CYC = 64,
    parameter int unsigned BLINK_W    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                reg_wr,
    input  logic                reg_rd,
    input  logic [ADDR_W-1:0]   reg_addr,
    input  logic [DATA_W-1:0]   reg_wdata,
    output logic [DATA_W-1:0]   reg_rdata,
    output logic                reg_rvalid,
    output logic [NUM_CHAN-1:0] rgb_pwm,
    output logic                rgbled_en,
    output logic                cbit_rgb_en,
    output logic                frame_sync
);

    localparam int unsigned PSC_HI_W = PSC_W - 8;
    localparam int unsigned SET_W    = $clog2(SETTLE_CYC + 1);

    ctrl_t               ctrl;
    ctrl_t               ctrl_nxt;
    logic [7:0]          psc_lo;
    logic [PSC_HI_W-1:0] psc_hi;
    logic [PSC_W-1:0]    psc_val;
    logic [DUTY_W-1:0]   duty_sh [NUM_CHAN];
    logic [BLINK_W-1:0]  on_time;
    logic [BLINK_W-1:0]  off_time;
    logic [DATA_W-1:0]   rd_mux;

    state_t              state;
    state_t              state_nxt;
    logic [SET_W-1:0]    settle_cnt;
    logic [SET_W-1:0]    settle_nxt;
    logic [PSC_W-1:0]    psc_cnt;
    logic [PSC_W-1:0]    psc_nxt;
    logic [DUTY_W-1:0]   pwm_cnt;
    logic [DUTY_W-1:0]   pwm_nxt;
    logic [BLINK_W-1:0]  wrap_cnt;
    logic [BLINK_W-1:0]  wrap_cnt_nxt;
    logic                tick;
    logic                wrap;
    logic                load;
    logic                run_nxt;
    logic                bias_nxt;
    logic                fsync_nxt;

    assign psc_val = {psc_hi, psc_lo};
    assign tick    = (psc_cnt == psc_val);
    assign wrap    = tick && (pwm_cnt == {DUTY_W{1'b1}});

    // A CTRL write is acted on by the FSM on the same edge it lands
    always_comb begin
        ctrl_nxt = ctrl;
        if (reg_wr && (reg_addr == ADDR_CTRL)) begin
            ctrl_nxt.en       = reg_wdata[CTRL_EN_BIT];
            ctrl_nxt.blink_en = reg_wdata[CTRL_BLINK_BIT];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ctrl     <= '0;
            psc_lo   <= '0;
            psc_hi   <= '0;
            on_time  <= '0;
            off_time <= '0;
            for (int i = 0; i < int'(NUM_CHAN); i++) begin
                duty_sh[i] <= '0;
            end
        end else begin
            ctrl <= ctrl_nxt;
            if (reg_wr) begin
                case (reg_addr)
                    ADDR_PSC_LO:   psc_lo     <= reg_wdata;
                    ADDR_PSC_HI:   psc_hi     <= reg_wdata[PSC_HI_W-1:0];
                    ADDR_DUTY0:    duty_sh[0] <= reg_wdata;
                    ADDR_DUTY1:    duty_sh[1] <= reg_wdata;
                    ADDR_DUTY2:    duty_sh[2] <= reg_wdata;
                    ADDR_ON_TIME:  on_time    <= BLINK_W'(reg_wdata);
                    ADDR_OFF_TIME: off_time   <= BLINK_W'(reg_wdata);
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        case (reg_addr)
            ADDR_CTRL:     rd_mux = DATA_W'(ctrl);
            ADDR_PSC_LO:   rd_mux = psc_lo;
            ADDR_PSC_HI:   rd_mux = DATA_W'(psc_hi);
            ADDR_DUTY0:    rd_mux = duty_sh[0];
            ADDR_DUTY1:    rd_mux = duty_sh[1];
            ADDR_DUTY2:    rd_mux = duty_sh[2];
            ADDR_ON_TIME:  rd_mux = DATA_W'(on_time);
            ADDR_OFF_TIME: rd_mux = DATA_W'(off_time);
            default:       rd_mux = '0;
        endcase
    end

    // Read data is sampled before any same-cycle write lands
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_rdata  <= '0;
            reg_rvalid <= 1'b0;
        end else begin
            reg_rvalid <= reg_rd;
            if (reg_rd) begin
                reg_rdata <= rd_mux;
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        settle_nxt   = settle_cnt;
        psc_nxt      = psc_cnt;
        pwm_nxt      = pwm_cnt;
        wrap_cnt_nxt = wrap_cnt;
        load         = 1'b0;
        fsync_nxt    = 1'b0;
        run_nxt      = 1'b0;
        bias_nxt     = 1'b0;

        case (state)
            ST_DISABLED: begin
                settle_nxt   = '0;
                psc_nxt      = '0;
                pwm_nxt      = '0;
                wrap_cnt_nxt = '0;
                state_nxt    = ST_SETTLE;
            end
            ST_SETTLE: begin
                psc_nxt      = '0;
                pwm_nxt      = '0;
                wrap_cnt_nxt = '0;
                if (settle_cnt == SET_W'(SETTLE_CYC - 1)) begin
                    settle_nxt = '0;
                    load       = 1'b1;
                    state_nxt  = ST_ON;
                end else begin
                    settle_nxt = settle_cnt + SET_W'(1);
                end
            end
            ST_ON, ST_OFF: begin
                if (tick) begin
                    psc_nxt = '0;
                    pwm_nxt = pwm_cnt + DUTY_W'(1);
                end else begin
                    psc_nxt = psc_cnt + PSC_W'(1);
                end
                // Blink phase accounting happens only at period boundaries
                if (wrap) begin
                    load      = 1'b1;
                    fsync_nxt = 1'b1;
                    if (state == ST_ON) begin
                        if (ctrl_nxt.blink_en && (off_time != '0) && (wrap_cnt == on_time)) begin
                            state_nxt    = ST_OFF;
                            wrap_cnt_nxt = '0;
                        end else begin
                            wrap_cnt_nxt = wrap_cnt + BLINK_W'(1);
                        end
                    end else begin
                        if (!ctrl_nxt.blink_en || (off_time == '0) ||
                            ((wrap_cnt + BLINK_W'(1)) == off_time)) begin
                            state_nxt    = ST_ON;
                            wrap_cnt_nxt = '0;
                        end else begin
                            wrap_cnt_nxt = wrap_cnt + BLINK_W'(1);
                        end
                    end
                end
            end
            default: state_nxt = ST_DISABLED;
        endcase

        if (!ctrl_nxt.en) begin
            state_nxt    = ST_DISABLED;
            settle_nxt   = '0;
            psc_nxt      = '0;
            pwm_nxt      = '0;
            wrap_cnt_nxt = '0;
            load         = 1'b0;
            fsync_nxt    = 1'b0;
        end

        run_nxt  = (state_nxt == ST_ON);
        bias_nxt = (state_nxt != ST_DISABLED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_DISABLED;
            settle_cnt  <= '0;
            psc_cnt     <= '0;
            pwm_cnt     <= '0;
            wrap_cnt    <= '0;
            rgbled_en   <= 1'b0;
            cbit_rgb_en <= 1'b0;
            frame_sync  <= 1'b0;
        end else begin
            state       <= state_nxt;
            settle_cnt  <= settle_nxt;
            psc_cnt     <= psc_nxt;
            pwm_cnt     <= pwm_nxt;
            wrap_cnt    <= wrap_cnt_nxt;
            rgbled_en   <= bias_nxt;
            cbit_rgb_en <= bias_nxt;
            frame_sync  <= fsync_nxt;
        end
    end

    for (genvar i = 0; i < int'(NUM_CHAN); i++) begin : g_chan
        rgb_pwm_chan u_chan (
            .clk         (clk),
            .rst         (rst),
            .load        (load),
            .run_nxt     (run_nxt),
            .duty_shadow (duty_sh[i]),
            .cnt_nxt     (pwm_nxt),
            .pwm         (rgb_pwm[i])
        );
    end

endmodule

// File: tb/tb_rgb_pwm_ctrl.sv
// Self-checking bench for rgb_pwm_ctrl: register port, settle timing,
// duty extremes and shadowing, blink sequencing, disable and reset.
module tb_rgb_pwm_ctrl;
    import rgb_pwm_pkg::*;

    logic       clk;
    logic       rst;
    logic       reg_wr;
    logic       reg_rd;
    logic [2:0] reg_addr;
    logic [7:0] reg_wdata;
    logic [7:0] reg_rdata;
    logic       reg_rvalid;
    logic [2:0] rgb_pwm;
    logic       rgbled_en;
    logic       cbit_rgb_en;
    logic       frame_sync;

    int total;
    int bad;

    // Reference model state: prescale, blink settings, shadow/active duties
    int pp;
    int on_m;
    int off_m;
    bit blink_m;
    int shd [3];
    int act [3];
    int hi_tot [3];
    int fs_tot;

    rgb_pwm_ctrl #(.PSC_W(10), .SETTLE_CYC(64), .BLINK_W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .reg_wr      (reg_wr),
        .reg_rd      (reg_rd),
        .reg_addr    (reg_addr),
        .reg_wdata   (reg_wdata),
        .reg_rdata   (reg_rdata),
        .reg_rvalid  (reg_rvalid),
        .rgb_pwm     (rgb_pwm),
        .rgbled_en   (rgbled_en),
        .cbit_rgb_en (cbit_rgb_en),
        .frame_sync  (frame_sync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        reg_wr    = 1'b1;
        reg_addr  = a;
        reg_wdata = d;
        step();
        reg_wr = 1'b0;
        if (a >= ADDR_DUTY0 && a <= ADDR_DUTY2) shd[int'(a) - 3] = int'(d);
    endtask

    task automatic rd(input logic [2:0] a, output logic [7:0] d, output logic v);
        reg_rd   = 1'b1;
        reg_addr = a;
        step();
        reg_rd = 1'b0;
        d = reg_rdata;
        v = reg_rvalid;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        for (int i = 0; i < 3; i++) shd[i] = 0;
        blink_m = 1'b0;
        on_m    = 0;
        off_m   = 0;
        pp      = 0;
    endtask

    // Enable, check bias comes up at once, then time the first PWM rise
    task automatic start_run(input logic [7:0] ctrl_v, input string tag);
        int k;
        wr(ADDR_CTRL, ctrl_v);
        chk({tag, "_bias"}, {rgbled_en, cbit_rgb_en, rgb_pwm}, 5'b11000);
        k = 0;
        while (!rgb_pwm[0] && k < 200) begin
            step();
            k++;
        end
        chk({tag, "_settle_len"}, k, 64);
    endtask

    // Cycle-by-cycle compare against the period/phase arithmetic model.
    // Called on the first cycle of ON (n = 0).
    task automatic run_check(input int ncyc, input int wr_n,
                             input logic [2:0] wr_a, input logic [7:0] wr_d);
        int period;
        period = 256 * (pp + 1);
        for (int i = 0; i < 3; i++) begin
            act[i]    = shd[i];
            hi_tot[i] = 0;
        end
        fs_tot = 0;
        for (int n = 0; n < ncyc; n++) begin
            int       k;
            int       off_in;
            int       cnt;
            bit       active;
            logic [2:0] ep;
            logic     efs;
            if (n > 0 && (n % period) == 0) begin
                for (int i = 0; i < 3; i++) act[i] = shd[i];
            end
            k      = n / period;
            off_in = n % period;
            cnt    = off_in / (pp + 1);
            active = !blink_m || (off_m == 0) || ((k % (on_m + 1 + off_m)) < (on_m + 1));
            for (int i = 0; i < 3; i++) ep[i] = active && (cnt < act[i]);
            efs = (n > 0) && (off_in == 0);
            chk($sformatf("run_n%0d", n), {frame_sync, rgbled_en, cbit_rgb_en, rgb_pwm},
                {efs, 1'b1, 1'b1, ep});
            for (int i = 0; i < 3; i++) if (rgb_pwm[i]) hi_tot[i]++;
            if (frame_sync) fs_tot++;
            if (n == wr_n) begin
                reg_wr    = 1'b1;
                reg_addr  = wr_a;
                reg_wdata = wr_d;
            end
            step();
            reg_wr = 1'b0;
            if (n == wr_n && wr_a >= ADDR_DUTY0 && wr_a <= ADDR_DUTY2) shd[int'(wr_a) - 3] = int'(wr_d);
        end
    endtask

    initial begin
        logic [7:0] d;
        logic [7:0] e;
        logic [7:0] got;
        logic       v;
        logic [7:0] d0;

        total = 0;
        bad   = 0;
        rst = 1'b0;
        reg_wr = 1'b0;
        reg_rd = 1'b0;
        reg_addr = '0;
        reg_wdata = '0;
        pp = 0; on_m = 0; off_m = 0; blink_m = 1'b0;
        for (int i = 0; i < 3; i++) shd[i] = 0;
        #1 rst = 1'b1;
        repeat (3) step();
        chk("rst_outputs", {reg_rvalid, frame_sync, rgbled_en, cbit_rgb_en, rgb_pwm}, 0);
        chk("rst_rdata", reg_rdata, 0);
        rst = 1'b0;
        step();
        chk("post_rst_outputs", {reg_rvalid, frame_sync, rgbled_en, cbit_rgb_en, rgb_pwm}, 0);

        // Reset values and readback of every address
        rd(ADDR_ON_TIME, got, v);
        chk("rst_on_time", {v, got}, {1'b1, 8'h00});
        rd(ADDR_OFF_TIME, got, v);
        chk("rst_off_time", {v, got}, {1'b1, 8'h00});
        for (int a = 0; a < 8; a++) begin
            d = 8'($urandom_range(0, 255));
            if (a == 0) d = d & 8'hFE;
            e = (a == 0) ? (d & 8'h02) : (a == 2) ? (d & 8'h03) : d;
            wr(3'(a), d);
            rd(3'(a), got, v);
            chk($sformatf("rd_valid_a%0d", a), v, 1);
            chk($sformatf("rd_data_a%0d", a), got, e);
            step();
            chk($sformatf("rd_hold_a%0d", a), {reg_rvalid, reg_rdata}, {1'b0, e});
        end
        wr(ADDR_DUTY1, 8'h5A);
        reg_wr = 1'b1; reg_rd = 1'b1; reg_addr = ADDR_DUTY1; reg_wdata = 8'hA5;
        step();
        reg_wr = 1'b0; reg_rd = 1'b0;
        chk("rw_same_old", {reg_rvalid, reg_rdata}, {1'b1, 8'h5A});
        rd(ADDR_DUTY1, got, v);
        chk("rw_same_new", got, 8'hA5);
        chk("idle_no_bias", {rgbled_en, rgb_pwm}, 0);

        // Settle timing, 50% duty, then async reset mid-PWM
        do_reset();
        rd(ADDR_CTRL, got, v);
        chk("rst_ctrl", got, 0);
        wr(ADDR_DUTY0, 8'd128);
        wr(ADDR_PSC_LO, 8'd0);
        wr(ADDR_PSC_HI, 8'd0);
        start_run(8'h01, "s1");
        run_check(512, -1, 3'd0, 8'd0);
        chk("s1_hi0", hi_tot[0], 256);
        chk("s1_fs", fs_tot, 1);
        chk("s1_pre_rst", rgb_pwm, 3'b001);
        rst = 1'b1;
        #1;
        chk("s1_async_rst", {reg_rvalid, frame_sync, rgbled_en, cbit_rgb_en, rgb_pwm}, 0);
        do_reset();

        // Duty extremes with PSC = 3
        d0 = 8'($urandom_range(1, 255));
        wr(ADDR_DUTY0, d0);
        wr(ADDR_DUTY1, 8'd0);
        wr(ADDR_DUTY2, 8'd255);
        wr(ADDR_PSC_LO, 8'd3);
        pp = 3;
        start_run(8'h01, "s2");
        run_check(2048, -1, 3'd0, 8'd0);
        chk("s2_hi0", hi_tot[0], 8 * int'(d0));
        chk("s2_hi1", hi_tot[1], 0);
        chk("s2_hi2", hi_tot[2], 2040);
        chk("s2_fs", fs_tot, 1);
        do_reset();

        // Mid-period duty write only takes effect at the next wrap
        wr(ADDR_DUTY0, 8'd100);
        start_run(8'h01, "s3");
        run_check(512, 50, ADDR_DUTY0, 8'd200);
        chk("s3_hi0", hi_tot[0], 300);
        do_reset();

        // Blink 2 periods on / 2 off, then disable in OFF and re-enable
        d0 = 8'($urandom_range(1, 255));
        wr(ADDR_DUTY0, d0);
        wr(ADDR_DUTY1, 8'($urandom_range(0, 255)));
        wr(ADDR_DUTY2, 8'($urandom_range(0, 255)));
        wr(ADDR_ON_TIME, 8'd1);
        wr(ADDR_OFF_TIME, 8'd2);
        blink_m = 1'b1; on_m = 1; off_m = 2;
        start_run(8'h03, "s4");
        run_check(1536, -1, 3'd0, 8'd0);
        chk("s4_hi0", hi_tot[0], 4 * int'(d0));
        chk("s4_in_off", {rgbled_en, cbit_rgb_en, rgb_pwm}, 5'b11000);
        wr(ADDR_CTRL, 8'h00);
        chk("s4_disable", {frame_sync, rgbled_en, cbit_rgb_en, rgb_pwm}, 0);
        blink_m = 1'b0;
        step();
        chk("s4_stay_off", {frame_sync, rgbled_en, cbit_rgb_en, rgb_pwm}, 0);
        start_run(8'h01, "s5");
        run_check(512, 100, ADDR_CTRL, 8'h01);
        chk("s5_hi0", hi_tot[0], 2 * int'(d0));
        chk("s5_fs", fs_tot, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls
    initial begin
        #2_000_000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
